// File: rtl/host_bus_if_pkg.sv
// Shared definitions for the host bus responder: default widths and FSM state encoding.
package host_bus_if_pkg;

    localparam int unsigned DefAddrW = 13;
    localparam int unsigned DefDataW = 8;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWrPulse = 3'd1,
        StRdWait  = 3'd2,
        StRdDrive = 3'd3,
        StRelease = 3'd4
    } hbState_e;

endpackage

// File: rtl/host_bus_if_strobe_sync.sv
// Multi-flop synchronizer for an active-low async host strobe, with a 1->0 edge detector
// on the synchronized level.
module host_bus_if_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic strobeN,
    output logic level,
    output logic fall
);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   prevQ;

    // Flops reset to 1 so a strobe already low at reset release still yields a fall.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            syncQ <= '1;
            prevQ <= 1'b1;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], strobeN};
            prevQ <= syncQ[SYNC_STAGES-1];
        end
    end

    always_comb begin
        level = syncQ[SYNC_STAGES-1];
        fall  = prevQ & ~syncQ[SYNC_STAGES-1];
    end

endmodule

// File: rtl/host_bus_if.sv
// Host-side bus responder: synchronizes host strobes, turns writes into VRAM write pulses and
// serves reads from the second VRAM port onto the host data bus via a registered enable.
module host_bus_if
    import host_bus_if_pkg::*;
#(
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostDataIn,
    input  logic              nHostRd,
    input  logic              nHostWr,
    output logic [DATA_W-1:0] hostDataOut,
    output logic              hostDataOe,
    output logic [ADDR_W-1:0] vramWrAddr,
    output logic [DATA_W-1:0] vramWrData,
    output logic              vramWr,
    output logic [ADDR_W-1:0] vramRdAddr2,
    input  logic [DATA_W-1:0] vramRdData2,
    output logic              busy,
    output logic              protoErr
);

    localparam int unsigned CntW = $clog2(RD_LATENCY + 1);

    logic rdLevel, rdFall, wrLevel, wrFall;

    host_bus_if_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rdSync (
        .clk    (clk),
        .nrst   (nrst),
        .strobeN(nHostRd),
        .level  (rdLevel),
        .fall   (rdFall)
    );

    host_bus_if_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_wrSync (
        .clk    (clk),
        .nrst   (nrst),
        .strobeN(nHostWr),
        .level  (wrLevel),
        .fall   (wrFall)
    );

    hbState_e          stateQ, stateD;
    logic [CntW-1:0]   cntQ, cntD;
    logic [ADDR_W-1:0] wrAddrQ, wrAddrD, rdAddrQ, rdAddrD;
    logic [DATA_W-1:0] wrDataQ, wrDataD, doutQ, doutD;
    logic              wrPulseQ, wrPulseD, oeQ, oeD, errQ, errD;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            wrAddrQ  <= '0;
            wrDataQ  <= '0;
            rdAddrQ  <= '0;
            doutQ    <= '0;
            wrPulseQ <= 1'b0;
            oeQ      <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            wrAddrQ  <= wrAddrD;
            wrDataQ  <= wrDataD;
            rdAddrQ  <= rdAddrD;
            doutQ    <= doutD;
            wrPulseQ <= wrPulseD;
            oeQ      <= oeD;
            errQ     <= errD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        wrAddrD  = wrAddrQ;
        wrDataD  = wrDataQ;
        rdAddrD  = rdAddrQ;
        doutD    = doutQ;
        wrPulseD = 1'b0;
        oeD      = 1'b0;
        errD     = errQ;

        unique case (stateQ)
            StIdle: begin
                if (wrFall && rdFall) begin
                    errD   = 1'b1;
                    stateD = StRelease;
                end else if (wrFall) begin
                    wrAddrD = hostAddr;
                    wrDataD = hostDataIn;
                    stateD  = StWrPulse;
                end else if (rdFall) begin
                    rdAddrD = hostAddr;
                    cntD    = '0;
                    stateD  = StRdWait;
                end
            end
            StWrPulse: begin
                // The registered pulse lands one edge later, while the FSM sits in StRelease.
                wrPulseD = 1'b1;
                if (rdFall) errD = 1'b1;
                stateD = StRelease;
            end
            StRdWait: begin
                if (wrFall) errD = 1'b1;
                if (rdLevel) begin
                    errD   = 1'b1;
                    stateD = StRelease;
                end else if (cntQ == CntW'(RD_LATENCY)) begin
                    doutD  = vramRdData2;
                    oeD    = 1'b1;
                    stateD = StRdDrive;
                end else begin
                    cntD = cntQ + CntW'(1);
                end
            end
            StRdDrive: begin
                if (wrFall) errD = 1'b1;
                if (rdLevel) stateD = StIdle;
                else         oeD    = 1'b1;
            end
            StRelease: begin
                if (rdFall || wrFall) errD = 1'b1;
                if (rdLevel && wrLevel) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        hostDataOut = doutQ;
        hostDataOe  = oeQ;
        vramWrAddr  = wrAddrQ;
        vramWrData  = wrDataQ;
        vramWr      = wrPulseQ;
        vramRdAddr2 = rdAddrQ;
        busy        = (stateQ != StIdle);
        protoErr    = errQ;
    end

endmodule

// File: tb/tb_host_bus_if.sv
// Self-checking bench for host_bus_if: table-driven write/read timing plus directed protocol
// corner cases on a default instance and an RD_LATENCY=2 instance.
module tb_host_bus_if;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic [AW-1:0] hostAddr;
    logic [DW-1:0] hostDataIn;
    logic          nRdA, nWrA, nRdB, nWrB;

    logic [DW-1:0] doutA, doutB, wrDataA, wrDataB, rdDataA, rdDataB, rdPipeB;
    logic [AW-1:0] wrAddrA, wrAddrB, rdAddrA, rdAddrB;
    logic          oeA, oeB, wrA, wrB, busyA, busyB, errA, errB;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    // VRAM second read port: 1-clock latency for A, 2-clock latency for B.
    always @(posedge clk) begin
        rdDataA <= mem[rdAddrA];
        rdPipeB <= mem[rdAddrB];
        rdDataB <= rdPipeB;
    end

    host_bus_if #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .RD_LATENCY(1)) dutA (
        .clk(clk), .nrst(nrst), .hostAddr(hostAddr), .hostDataIn(hostDataIn),
        .nHostRd(nRdA), .nHostWr(nWrA), .hostDataOut(doutA), .hostDataOe(oeA),
        .vramWrAddr(wrAddrA), .vramWrData(wrDataA), .vramWr(wrA), .vramRdAddr2(rdAddrA),
        .vramRdData2(rdDataA), .busy(busyA), .protoErr(errA)
    );

    host_bus_if #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .RD_LATENCY(2)) dutB (
        .clk(clk), .nrst(nrst), .hostAddr(hostAddr), .hostDataIn(hostDataIn),
        .nHostRd(nRdB), .nHostWr(nWrB), .hostDataOut(doutB), .hostDataOe(oeB),
        .vramWrAddr(wrAddrB), .vramWrData(wrDataB), .vramWr(wrB), .vramRdAddr2(rdAddrB),
        .vramRdData2(rdDataB), .busy(busyB), .protoErr(errB)
    );

    typedef struct {
        logic          nWr;
        logic          nRd;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          expWr;
        logic          expOe;
        logic          expBusy;
        logic [DW-1:0] expDout;
        int            reps;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int edgeN;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i) ^ 8'h55;
        mem[13'h1FFF] = 8'h3C;
        mem[13'h0042] = 8'h5A;

        // Test 1: write (rows 0-5); Test 2: read of 0x1FFF (rows 6-10). Edges count from 1.
        vecs[0]  = '{1'b0, 1'b1, 13'h0123, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 2};
        vecs[1]  = '{1'b0, 1'b1, 13'h0123, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 1};
        vecs[2]  = '{1'b0, 1'b1, 13'h0123, 8'hA5, 1'b1, 1'b0, 1'b1, 8'h00, 1};
        vecs[3]  = '{1'b0, 1'b1, 13'h0123, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 4};
        vecs[4]  = '{1'b1, 1'b1, 13'h0123, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 2};
        vecs[5]  = '{1'b1, 1'b1, 13'h0123, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 2};
        vecs[6]  = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2};
        vecs[7]  = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 2};
        vecs[8]  = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 6};
        vecs[9]  = '{1'b1, 1'b1, 13'h1FFF, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 2};
        vecs[10] = '{1'b1, 1'b1, 13'h1FFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 2};

        nrst = 1'b0; nRdA = 1'b1; nWrA = 1'b1; nRdB = 1'b1; nWrB = 1'b1;
        hostAddr = '0; hostDataIn = '0;
        step(); step();
        chk("reset wr",    32'(wrA),   32'(1'b0));
        chk("reset oe",    32'(oeA),   32'(1'b0));
        chk("reset busy",  32'(busyA), 32'(1'b0));
        chk("reset err",   32'(errA),  32'(1'b0));
        chk("reset dout",  32'(doutA), 32'(8'h00));
        chk("reset wradr", 32'(wrAddrA), 32'(13'h0000));
        chk("reset rdadr", 32'(rdAddrA), 32'(13'h0000));
        nrst = 1'b1;

        edgeN = 0;
        for (int r = 0; r < 11; r++) begin
            for (int k = 0; k < vecs[r].reps; k++) begin
                nWrA = vecs[r].nWr; nRdA = vecs[r].nRd;
                hostAddr = vecs[r].addr; hostDataIn = vecs[r].din;
                step();
                edgeN++;
                chk($sformatf("vec%0d e%0d wr", r, edgeN),   32'(wrA),   32'(vecs[r].expWr));
                chk($sformatf("vec%0d e%0d oe", r, edgeN),   32'(oeA),   32'(vecs[r].expOe));
                chk($sformatf("vec%0d e%0d busy", r, edgeN), 32'(busyA), 32'(vecs[r].expBusy));
                chk($sformatf("vec%0d e%0d dout", r, edgeN), 32'(doutA), 32'(vecs[r].expDout));
                chk($sformatf("vec%0d e%0d err", r, edgeN),  32'(errA),  32'(1'b0));
            end
            if (r == 5) edgeN = 0;
        end
        chk("t1 wraddr", 32'(wrAddrA), 32'(13'h0123));
        chk("t1 wrdata", 32'(wrDataA), 32'(8'hA5));
        chk("t2 rdaddr", 32'(rdAddrA), 32'(13'h1FFF));

        // Test 3: both strobes fall in the same clock.
        hostAddr = 13'h0555; hostDataIn = 8'h11;
        nWrA = 1'b0; nRdA = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            step();
            chk($sformatf("t3 e%0d wr", n),   32'(wrA),   32'(1'b0));
            chk($sformatf("t3 e%0d oe", n),   32'(oeA),   32'(1'b0));
            chk($sformatf("t3 e%0d err", n),  32'(errA),  32'(n >= 3));
            chk($sformatf("t3 e%0d busy", n), 32'(busyA), 32'(n >= 3));
        end
        nWrA = 1'b1; nRdA = 1'b1;
        for (int n = 7; n <= 10; n++) begin
            step();
            chk($sformatf("t3 e%0d busy", n), 32'(busyA), 32'(n <= 8));
            chk($sformatf("t3 e%0d err", n),  32'(errA),  32'(1'b1));
            chk($sformatf("t3 e%0d dout", n), 32'(doutA), 32'(8'h3C));
        end

        // Test 4: write strobe falls while the read is being driven.
        nrst = 1'b0; step(); nrst = 1'b1;
        chk("t4 reset err",  32'(errA),  32'(1'b0));
        chk("t4 reset dout", 32'(doutA), 32'(8'h00));
        hostAddr = 13'h0042; hostDataIn = 8'hEE;
        nRdA = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 6) nWrA = 1'b0;
            chk($sformatf("t4 e%0d wr", n),   32'(wrA),   32'(1'b0));
            chk($sformatf("t4 e%0d oe", n),   32'(oeA),   32'(n >= 5));
            chk($sformatf("t4 e%0d err", n),  32'(errA),  32'(n >= 9));
            chk($sformatf("t4 e%0d dout", n), 32'(doutA), (n >= 5) ? 32'(8'h5A) : 32'(8'h00));
        end
        nRdA = 1'b1;
        for (int n = 13; n <= 16; n++) begin
            step();
            chk($sformatf("t4 e%0d oe", n),   32'(oeA),   32'(n <= 14));
            chk($sformatf("t4 e%0d busy", n), 32'(busyA), 32'(n <= 14));
            chk($sformatf("t4 e%0d wr", n),   32'(wrA),   32'(1'b0));
        end
        nWrA = 1'b1;
        for (int n = 17; n <= 19; n++) begin
            step();
            chk($sformatf("t4 e%0d busy", n), 32'(busyA), 32'(1'b0));
            chk($sformatf("t4 e%0d wr", n),   32'(wrA),   32'(1'b0));
        end

        // Test 5: one-clock reset during RD_DRIVE, then a normal write.
        hostAddr = 13'h1FFF;
        nRdA = 1'b0;
        for (int n = 1; n <= 6; n++) step();
        chk("t5 oe before reset",  32'(oeA),  32'(1'b1));
        chk("t5 err before reset", 32'(errA), 32'(1'b1));
        nrst = 1'b0; nRdA = 1'b1;
        step();
        chk("t5 reset oe",   32'(oeA),   32'(1'b0));
        chk("t5 reset busy", 32'(busyA), 32'(1'b0));
        chk("t5 reset err",  32'(errA),  32'(1'b0));
        chk("t5 reset dout", 32'(doutA), 32'(8'h00));
        nrst = 1'b1;
        hostAddr = 13'h0ABC; hostDataIn = 8'h7E;
        nWrA = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            step();
            chk($sformatf("t5 e%0d wr", n), 32'(wrA), 32'(n == 4));
            if (n == 4) begin
                chk("t5 wraddr", 32'(wrAddrA), 32'(13'h0ABC));
                chk("t5 wrdata", 32'(wrDataA), 32'(8'h7E));
            end
        end
        nWrA = 1'b1;
        for (int n = 7; n <= 10; n++) step();
        chk("t5 end busy", 32'(busyA), 32'(1'b0));
        chk("t5 end err",  32'(errA),  32'(1'b0));

        // Test 6: RD_LATENCY=2 instance, read strobe low for only 3 clocks.
        hostAddr = 13'h1FFF;
        nRdB = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 3) nRdB = 1'b1;
            chk($sformatf("t6 e%0d oe", n),   32'(oeB),   32'(1'b0));
            chk($sformatf("t6 e%0d err", n),  32'(errB),  32'(n >= 6));
            chk($sformatf("t6 e%0d busy", n), 32'(busyB), 32'(n >= 3 && n <= 6));
            chk($sformatf("t6 e%0d wr", n),   32'(wrB),   32'(1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
